axi4_slave_ctrl: RTL

//  AXI4 slave front-end for the single-port word memory (axi4_memory). Accepts AXI4 read/write bursts
//  (FIXED/INCR/WRAP), arbitrates them onto the one mem_en/mem_we/mem_addr port and returns B/R responses.

---
 rtl/axi4_pkg.sv | 39 +++
 rtl/axi4_addr_gen.sv | 28 ++
 rtl/axi4_slave_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/axi4_pkg.sv
// Shared constants, FSM state type and small helpers for the AXI4 slave front-end.
package axi4_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_MEM,
        ST_RD_DATA
    } state_t;

    // Number of byte lanes in one data word.
    function automatic int nb_of(input int data_width);
        return data_width / 8;
    endfunction

    // log2 of the byte-lane count: the byte-address bits below the word address.
    function automatic int nb_log2(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // A burst is unserviceable if it is narrower than a word, uses the reserved
    // burst encoding, or is a WRAP whose length is not 2, 4, 8 or 16 beats.
    function automatic logic burst_is_bad(input logic [2:0] size, input logic [1:0] burst,
                                          input logic [7:0] len, input int size_log2);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (int'(size) != size_log2) || (burst == 2'b11) ||
               ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

endpackage

// File: rtl/axi4_addr_gen.sv
// Next word address of a burst, given the current word address, burst type and length.
module axi4_addr_gen
    import axi4_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic [MEM_ADDR_WIDTH-1:0] cur,
    input  logic [7:0]                len,
    input  logic [1:0]                burst,
    output logic [MEM_ADDR_WIDTH-1:0] next
);

    logic [MEM_ADDR_WIDTH-1:0] incr;
    logic [MEM_ADDR_WIDTH-1:0] wrap_mask;

    // WRAP keeps the bits above the (len+1)-word window and increments inside it;
    // legal WRAP lengths are 2^n-1, so len itself is the in-window mask.
    always_comb begin
        incr      = cur + MEM_ADDR_WIDTH'(1);
        wrap_mask = MEM_ADDR_WIDTH'(len);
        case (burst)
            BURST_FIXED: next = cur;
            BURST_WRAP:  next = (cur & ~wrap_mask) | (incr & wrap_mask);
            default:     next = incr;
        endcase
    end

endmodule

// File: rtl/axi4_slave_ctrl.sv
// AXI4 slave front-end for a single-port word memory; one burst in flight at a time.
// Handshake rule on every channel: a transfer happens on the clock edge where
// valid and ready are both high; a source holds valid and payload until then.
module axi4_slave_ctrl
    import axi4_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int ID_WIDTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ID_WIDTH-1:0]         awid,
    input  logic [ADDR_WIDTH-1:0]       awaddr,
    input  logic [7:0]                  awlen,
    input  logic [2:0]                  awsize,
    input  logic [1:0]                  awburst,
    input  logic                        awvalid,
    output logic                        awready,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [DATA_WIDTH/8-1:0]     wstrb,
    input  logic                        wlast,
    input  logic                        wvalid,
    output logic                        wready,
    output logic [ID_WIDTH-1:0]         bid,
    output logic [1:0]                  bresp,
    output logic                        bvalid,
    input  logic                        bready,
    input  logic [ID_WIDTH-1:0]         arid,
    input  logic [ADDR_WIDTH-1:0]       araddr,
    input  logic [7:0]                  arlen,
    input  logic [2:0]                  arsize,
    input  logic [1:0]                  arburst,
    input  logic                        arvalid,
    output logic                        arready,
    output logic [ID_WIDTH-1:0]         rid,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic [1:0]                  rresp,
    output logic                        rlast,
    output logic                        rvalid,
    input  logic                        rready,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    input  logic [DATA_WIDTH-1:0]       mem_rdata
);

    localparam int NBL = nb_log2(DATA_WIDTH);

    state_t                    state;
    logic                      last_write_q;   // 1: last served burst was a write
    logic [ID_WIDTH-1:0]       id_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_next;
    logic [7:0]                len_q;
    logic [7:0]                cnt_q;
    logic [1:0]                burst_q;
    logic                      err_q;
    logic                      wr_err_q;
    logic                      rd_first_q;     // first RD_DATA cycle: memory output is live
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic [DATA_WIDTH-1:0]     rd_word;
    logic                      grant_wr;
    logic                      grant_rd;
    logic                      last_beat;
    logic                      beat_err;
    logic                      unused_addr_bits;

    assign unused_addr_bits = ^{awaddr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+NBL], awaddr[NBL-1:0],
                                araddr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+NBL], araddr[NBL-1:0]};

    axi4_addr_gen #(.MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)) u_addr_gen (
        .cur   (addr_q),
        .len   (len_q),
        .burst (burst_q),
        .next  (addr_next)
    );

    // Arbitration: a lone request wins; on a tie the type not served last wins.
    always_comb begin
        grant_wr = awvalid && (!arvalid || !last_write_q);
        grant_rd = arvalid && !grant_wr;
    end

    assign awready   = (state == ST_IDLE) && grant_wr;
    assign arready   = (state == ST_IDLE) && grant_rd;
    assign wready    = (state == ST_WR_DATA);
    assign last_beat = (cnt_q == len_q);
    assign beat_err  = err_q || !(&wstrb) || (wlast != last_beat);
    assign rd_word   = err_q ? '0 : mem_rdata;
    // Memory data is only valid in the first RD_DATA cycle; afterwards the captured copy holds it.
    assign rdata     = rd_first_q ? rd_word : rdata_q;

    // Memory port: write beats pass straight through; reads are issued from RD_MEM.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata;
        if (state == ST_WR_DATA && wvalid) begin
            mem_en = 1'b1;
            mem_we = !err_q && (&wstrb);
        end else if (state == ST_RD_MEM) begin
            mem_en = 1'b1;
        end
    end

    // Burst FSM with latched request, beat counter and registered B/R channel outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            last_write_q <= 1'b0;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            burst_q      <= '0;
            err_q        <= 1'b0;
            wr_err_q     <= 1'b0;
            rd_first_q   <= 1'b0;
            rdata_q      <= '0;
            bvalid       <= 1'b0;
            bresp        <= RESP_OKAY;
            bid          <= '0;
            rvalid       <= 1'b0;
            rresp        <= RESP_OKAY;
            rlast        <= 1'b0;
            rid          <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (awready) begin
                        id_q     <= awid;
                        addr_q   <= awaddr[MEM_ADDR_WIDTH+NBL-1:NBL];
                        len_q    <= awlen;
                        burst_q  <= awburst;
                        err_q    <= burst_is_bad(awsize, awburst, awlen, NBL);
                        wr_err_q <= 1'b0;
                        cnt_q    <= '0;
                        state    <= ST_WR_DATA;
                    end else if (arready) begin
                        id_q    <= arid;
                        addr_q  <= araddr[MEM_ADDR_WIDTH+NBL-1:NBL];
                        len_q   <= arlen;
                        burst_q <= arburst;
                        err_q   <= burst_is_bad(arsize, arburst, arlen, NBL);
                        cnt_q   <= '0;
                        state   <= ST_RD_MEM;
                    end
                end
                ST_WR_DATA: begin
                    if (wvalid) begin
                        addr_q <= addr_next;
                        if (last_beat) begin
                            bvalid <= 1'b1;
                            bid    <= id_q;
                            bresp  <= (wr_err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                            state  <= ST_WR_RESP;
                        end else begin
                            cnt_q    <= cnt_q + 8'd1;
                            wr_err_q <= wr_err_q || beat_err;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (bready) begin
                        bvalid       <= 1'b0;
                        last_write_q <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                ST_RD_MEM: begin
                    rvalid     <= 1'b1;
                    rid        <= id_q;
                    rresp      <= err_q ? RESP_SLVERR : RESP_OKAY;
                    rlast      <= last_beat;
                    rd_first_q <= 1'b1;
                    state      <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (rd_first_q) begin
                        rdata_q    <= rd_word;
                        rd_first_q <= 1'b0;
                    end
                    if (rready) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        if (rlast) begin
                            last_write_q <= 1'b0;
                            state        <= ST_IDLE;
                        end else begin
                            addr_q <= addr_next;
                            cnt_q  <= cnt_q + 8'd1;
                            state  <= ST_RD_MEM;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
